// File: rtl/ysyx_22041211_lsu.sv
// Multi-cycle load/store unit between the execute stage and a valid/ready data bus.
// Optional: define YSYX_22041211_LSU_MISALIGN_TRAP_EN to reject accesses not naturally aligned to their length.
// Handshake: a transfer happens on a clock edge where valid && ready; the sender holds all payload
// stable while valid is high and ready is low. resp_valid and mem_rvalid are single-cycle pulses.

module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  input  logic [3:0]            req_len,
  input  logic                  req_sign,
  output logic                  resp_valid,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic [DATA_LEN/8-1:0] mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_LEN-1:0]   mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam int STRB = DATA_LEN / 8;
  localparam int OFFW = $clog2(STRB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_n;

  logic                we_q, sign_q, err_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q, rdata_q;
  logic [3:0]          len_q;
  logic [7:0]          cnt;

  logic len_ok, req_legal, wait_expired;

  always_comb begin
    len_ok = 1'b0;
    case (req_len)
      4'b0001, 4'b0010, 4'b0100: len_ok = 1'b1;
      4'b1000:                   len_ok = (DATA_LEN == 64);
      default:                   len_ok = 1'b0;
    endcase
`ifdef YSYX_22041211_LSU_MISALIGN_TRAP_EN
    // Low address bits that must be zero for a naturally aligned access of this length.
    req_legal = len_ok &&
                ((req_addr[2:0] & {req_len[3], |req_len[3:2], |req_len[3:1]}) == 3'b000);
`else
    req_legal = len_ok;
`endif
  end

  assign wait_expired = (cnt == 8'(TIMEOUT - 1));

  // Lane steering: everything is relative to the byte offset inside the bus word.
  logic [OFFW-1:0]     off;
  logic [OFFW+2:0]     sh;
  logic [STRB-1:0]     len_mask;
  logic [DATA_LEN-1:0] lane_wdata, rd_shift, bit_mask, load_ext;
  logic                sbit;

  assign off = addr_q[OFFW-1:0];
  assign sh  = {off, 3'b000};

  always_comb begin
    len_mask = '0;
    case (len_q)
      4'b0001: len_mask = STRB'(8'h01);
      4'b0010: len_mask = STRB'(8'h03);
      4'b0100: len_mask = STRB'(8'h0F);
      4'b1000: len_mask = STRB'(8'hFF);
      default: len_mask = '0;
    endcase
  end

  always_comb begin
    lane_wdata = wdata_q << sh;
    rd_shift   = mem_rdata >> sh;
    bit_mask   = '0;
    for (int i = 0; i < STRB; i++) begin
      bit_mask[8*i +: 8] = {8{len_mask[i]}};
    end
    // Lanes beyond the bus word read as zero, so a truncated load takes its sign from a zero byte.
    case (len_q)
      4'b0001: sbit = rd_shift[7];
      4'b0010: sbit = rd_shift[15];
      4'b0100: sbit = rd_shift[31];
      default: sbit = rd_shift[DATA_LEN-1];
    endcase
    load_ext = (rd_shift & bit_mask) | ((sign_q && sbit) ? ~bit_mask : '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_valid) state_n = req_legal ? S_REQ : S_DONE;
      S_REQ:  if (mem_ready) state_n = S_WAIT;
      S_WAIT: if (mem_rvalid || wait_expired) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          sign_q  <= req_sign;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          len_q   <= req_len;
          err_q   <= !req_legal;
          rdata_q <= '0;
          cnt     <= '0;
        end
        S_REQ: if (mem_ready) cnt <= '0;
        S_WAIT: begin
          // A response in the limit cycle still wins over the timeout.
          if (mem_rvalid)        rdata_q <= we_q ? '0 : load_ext;
          else if (wait_expired) err_q   <= 1'b1;
          else                   cnt     <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign mem_valid  = (state == S_REQ);
  assign mem_we     = mem_valid && we_q;
  assign mem_addr   = mem_valid ? (addr_q & ~ADDR_LEN'(STRB - 1)) : '0;
  assign mem_wdata  = mem_valid ? lane_wdata : '0;
  assign mem_wstrb  = mem_valid ? (len_mask << off) : '0;
  assign resp_valid = (state == S_DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Self-checking bench for ysyx_22041211_lsu: directed scenarios plus randomized transactions
// compared against a byte-level reference model of lane steering, extension and latency.

module tb_ysyx_22041211_lsu;

  localparam int D  = 32;
  localparam int A  = 32;
  localparam int TO = 16;
  localparam int NB = D / 8;
`ifdef YSYX_22041211_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_sign;
  logic [A-1:0]  req_addr;
  logic [D-1:0]  req_wdata;
  logic [3:0]    req_len;
  logic          resp_valid, resp_err;
  logic [D-1:0]  resp_rdata;
  logic          mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [A-1:0]  mem_addr;
  logic [D-1:0]  mem_wdata, mem_rdata;
  logic [NB-1:0] mem_wstrb;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [D-1:0] exp_q[$];

  ysyx_22041211_lsu #(.DATA_LEN(D), .ADDR_LEN(A), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [3:0] len);
    case (len)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [A-1:0] addr, input logic [3:0] len);
    int nb;
    bit misaligned;
    nb = nbytes_of(len);
    if (nb == 0 || nb > NB) return 1'b0;
    misaligned = (int'(addr % A'(nb)) != 0);
    return !(TRAP_EN && misaligned);
  endfunction

  function automatic logic [NB-1:0] model_strb(input logic [A-1:0] addr, input logic [3:0] len);
    int off, nb;
    logic [NB-1:0] s;
    off = int'(addr % A'(NB));
    nb  = nbytes_of(len);
    s   = '0;
    for (int b = 0; b < NB; b++) s[b] = (b >= off) && (b < off + nb);
    return s;
  endfunction

  function automatic logic [D-1:0] model_wdata(input logic [A-1:0] addr, input logic [D-1:0] wd);
    int off;
    logic [D-1:0] v;
    off = int'(addr % A'(NB));
    v   = '0;
    for (int b = off; b < NB; b++) v[8*b +: 8] = wd[8*(b-off) +: 8];
    return v;
  endfunction

  function automatic logic [D-1:0] model_load(input logic [A-1:0] addr, input logic [3:0] len,
                                              input logic sign, input logic [D-1:0] bus);
    int off, nb;
    logic [D-1:0] v;
    logic [7:0] byte_v;
    off    = int'(addr % A'(NB));
    nb     = nbytes_of(len);
    v      = '0;
    byte_v = '0;
    for (int i = 0; i < nb; i++) begin
      byte_v = (off + i < NB) ? bus[8*(off+i) +: 8] : 8'h00;
      v[8*i +: 8] = byte_v;
    end
    if (sign && byte_v[7]) for (int i = nb; i < NB; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Cycles from the accept cycle to the resp_valid cycle.
  function automatic int exp_latency(input int ready_dly, input int resp_dly);
    return 2 + ready_dly + ((resp_dly < TO) ? resp_dly + 1 : TO);
  endfunction

  function automatic logic [D-1:0] rand_data();
    return D'({$urandom(), $urandom()});
  endfunction

  // ---------------- driver ----------------
  typedef struct {
    int            lat;
    logic          err;
    logic [D-1:0]  rdata;
    int            mv_cycles;
    logic          we;
    logic [A-1:0]  addr;
    logic [D-1:0]  wdata;
    logic [NB-1:0] strb;
    bit            stable;
    bit            ready_busy;
    logic          post_ready;
    logic          post_resp;
  } obs_t;

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic drive_txn(input logic we, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                           input logic [3:0] len, input logic sign, input int ready_dly,
                           input int resp_dly, input logic [D-1:0] bus_data, output obs_t o);
    int c, w;
    bit hs, hs_pending, got;
    o.lat = -1; o.err = 1'b0; o.rdata = '0; o.mv_cycles = 0; o.we = 1'b0; o.addr = '0;
    o.wdata = '0; o.strb = '0; o.stable = 1'b1; o.ready_busy = 1'b0;
    o.post_ready = 1'b0; o.post_resp = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_len = len; req_sign = sign;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = rand_data();
    req_len   = 4'($urandom_range(0, 15));
    c = 1; w = 0; hs = 1'b0; hs_pending = 1'b0; got = 1'b0;
    while (!got && c < 200) begin
      if (hs_pending) begin hs = 1'b1; hs_pending = 1'b0; end
      if (resp_valid) begin
        got = 1'b1; o.lat = c; o.err = resp_err; o.rdata = resp_rdata;
      end else begin
        if (req_ready) o.ready_busy = 1'b1;
        if (mem_valid) begin
          if (o.mv_cycles == 0) begin
            o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata; o.strb = mem_wstrb;
          end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {o.we, o.addr, o.wdata, o.strb}) begin
            o.stable = 1'b0;
          end
          mem_ready  = (o.mv_cycles == ready_dly);
          hs_pending = mem_ready;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata  = rand_data();
          o.mv_cycles++;
        end else if (hs) begin
          mem_ready  = 1'b0;
          mem_rvalid = (w == resp_dly);
          mem_rdata  = (w == resp_dly) ? bus_data : rand_data();
          w++;
        end else begin
          mem_ready = 1'b0; mem_rvalid = 1'b0;
        end
      end
      if (!got) begin @(negedge clk); c++; end
    end
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    o.post_ready = req_ready;
    o.post_resp  = resp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; req_sign = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_valid, mem_we} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, resp_valid, resp_err, mem_valid, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, resp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr %h wdata %h strb %b rdata %h expected all zero",
               mem_addr, mem_wdata, mem_wstrb, resp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_load();
    obs_t o;
    drive_txn(1'b0, 32'h8000_0003, '0, 4'b0001, 1'b1, 0, 0, 32'h8011_2233, o);
    checks++; if (o.addr !== 32'h8000_0000) begin failures++; $display("FAIL byte_load_addr: got %h expected 80000000", o.addr); end
    checks++; if (o.rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL byte_load_rdata: got %h expected ffffff80", o.rdata); end
    checks++; if (o.lat != 3) begin failures++; $display("FAIL byte_load_latency: got %0d expected 3", o.lat); end
    checks++; if (o.err !== 1'b0 || o.we !== 1'b0) begin failures++; $display("FAIL byte_load_flags: err %b we %b expected 0 0", o.err, o.we); end
    checks++; if (o.post_resp !== 1'b0) begin failures++; $display("FAIL byte_load_pulse: resp_valid %b after pulse expected 0", o.post_resp); end
  endtask

  task automatic test_half_store();
    obs_t o;
    drive_txn(1'b1, 32'h8000_0002, 32'h0000_BEEF, 4'b0010, 1'b0, 0, 3, rand_data(), o);
    checks++; if (o.strb !== 4'b1100) begin failures++; $display("FAIL half_store_strb: got %b expected 1100", o.strb); end
    checks++; if (o.wdata !== 32'hBEEF_0000) begin failures++; $display("FAIL half_store_wdata: got %h expected beef0000", o.wdata); end
    checks++; if (o.we !== 1'b1) begin failures++; $display("FAIL half_store_we: got %b expected 1", o.we); end
    checks++; if (o.lat != 6 || o.err !== 1'b0) begin failures++; $display("FAIL half_store_resp: lat %0d err %b expected 6 0", o.lat, o.err); end
    checks++; if (o.rdata !== '0) begin failures++; $display("FAIL half_store_rdata: got %h expected 0", o.rdata); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [D-1:0] wd;
    wd = rand_data();
    drive_txn(1'b1, 32'h8000_0009, wd, 4'b0001, 1'b0, 5, 1, rand_data(), o);
    checks++; if (o.mv_cycles != 6) begin failures++; $display("FAIL bp_valid_cycles: got %0d expected 6", o.mv_cycles); end
    checks++; if (!o.stable) begin failures++; $display("FAIL bp_stable: got unstable expected stable"); end
    checks++; if (o.ready_busy) begin failures++; $display("FAIL bp_req_ready: got 1 while busy expected 0"); end
    checks++; if (o.wdata !== model_wdata(32'h8000_0009, wd)) begin failures++; $display("FAIL bp_wdata: got %h expected %h", o.wdata, model_wdata(32'h8000_0009, wd)); end
    checks++; if (o.lat != exp_latency(5, 1)) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", o.lat, exp_latency(5, 1)); end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [D-1:0] bus;
    drive_txn(1'b0, 32'h8000_0100, '0, 4'b0100, 1'b0, 0, 1000, '0, o);
    checks++; if (o.err !== 1'b1 || o.rdata !== '0) begin failures++; $display("FAIL timeout_err: err %b rdata %h expected 1 0", o.err, o.rdata); end
    checks++; if (o.lat != TO + 2) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", o.lat, TO + 2); end
    checks++; if (o.post_ready !== 1'b1) begin failures++; $display("FAIL timeout_idle: req_ready %b expected 1", o.post_ready); end
    bus = rand_data();
    drive_txn(1'b0, 32'h8000_0104, '0, 4'b0100, 1'b0, 0, TO - 1, bus, o);
    checks++; if (o.err !== 1'b0 || o.rdata !== bus) begin failures++; $display("FAIL timeout_edge_win: err %b rdata %h expected 0 %h", o.err, o.rdata, bus); end
    checks++; if (o.lat != TO + 2) begin failures++; $display("FAIL timeout_edge_latency: got %0d expected %0d", o.lat, TO + 2); end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [3:0] bad_lens [4];
    logic [D-1:0] bus;
    bad_lens = '{4'b1000, 4'b0011, 4'b0000, 4'b0110};
    foreach (bad_lens[i]) begin
      drive_txn(1'($urandom_range(0, 1)), 32'h8000_0000, rand_data(), bad_lens[i], 1'b1, 0, 0, rand_data(), o);
      checks++;
      if (o.err !== 1'b1 || o.mv_cycles != 0 || o.lat != 1 || o.rdata !== '0) begin
        failures++;
        $display("FAIL illegal_len_%b: err %b bus_cycles %0d lat %0d rdata %h expected 1 0 1 0",
                 bad_lens[i], o.err, o.mv_cycles, o.lat, o.rdata);
      end
    end
    bus = 32'hAABB_CCDD;
    drive_txn(1'b0, 32'h8000_0002, '0, 4'b0100, 1'b0, 0, 0, bus, o);
    if (TRAP_EN) begin
      checks++;
      if (o.err !== 1'b1 || o.mv_cycles != 0 || o.lat != 1 || o.rdata !== '0) begin
        failures++;
        $display("FAIL misalign_trap: err %b bus_cycles %0d lat %0d rdata %h expected 1 0 1 0",
                 o.err, o.mv_cycles, o.lat, o.rdata);
      end
    end else begin
      checks++;
      if (o.err !== 1'b0 || o.rdata !== 32'h0000_AABB || o.lat != 3) begin
        failures++;
        $display("FAIL misalign_truncate: err %b rdata %h lat %0d expected 0 0000aabb 3", o.err, o.rdata, o.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit seen;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; req_len = 4'b0100; req_sign = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_mid_req: mem_valid 0 expected 1"); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_valid, resp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL rst_mid_state: ready/mem_valid/resp_valid %b expected 100", {req_ready, mem_valid, resp_valid});
    end
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rand_data();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_resp: resp_valid %b expected 0", resp_valid); end
    end
    mem_rvalid = 1'b0;
    drive_txn(1'b0, 32'h8000_0004, '0, 4'b0100, 1'b0, 0, 0, 32'h1234_5678, o);
    checks++;
    if (o.rdata !== 32'h1234_5678 || o.err !== 1'b0 || o.lat != 3) begin
      failures++;
      $display("FAIL rst_mid_recover: rdata %h err %b lat %0d expected 12345678 0 3", o.rdata, o.err, o.lat);
    end
  endtask

  task automatic test_random(input int n);
    obs_t o;
    logic we, sign, legal;
    logic [A-1:0] addr;
    logic [3:0] len;
    logic [D-1:0] wd, bus, exp_rd;
    int rd, rs;
    for (int k = 0; k < n; k++) begin
      we   = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       len = 4'($urandom_range(0, 15));
        1, 2, 3: len = 4'b0001;
        4, 5:    len = 4'b0010;
        6, 7, 8: len = 4'b0100;
        default: len = 4'b1000;
      endcase
      rd   = $urandom_range(0, 3);
      rs   = ($urandom_range(0, 14) == 0) ? TO + 3 : $urandom_range(0, 5);
      wd   = rand_data();
      bus  = rand_data();
      legal = model_legal(addr, len);
      exp_q.push_back((!legal || we || rs >= TO) ? '0 : model_load(addr, len, sign, bus));
      drive_txn(we, addr, wd, len, sign, rd, rs, bus, o);
      exp_rd = exp_q.pop_front();
      checks++;
      if (o.rdata !== exp_rd || o.err !== (!legal || rs >= TO)) begin
        failures++;
        $display("FAIL rand_resp[%0d]: rdata %h err %b expected %h %b (addr %h len %b sign %b)",
                 k, o.rdata, o.err, exp_rd, (!legal || rs >= TO), addr, len, sign);
      end
      checks++;
      if (o.lat != (legal ? exp_latency(rd, rs) : 1) || o.mv_cycles != (legal ? rd + 1 : 0)) begin
        failures++;
        $display("FAIL rand_timing[%0d]: lat %0d bus_cycles %0d expected %0d %0d", k, o.lat, o.mv_cycles,
                 legal ? exp_latency(rd, rs) : 1, legal ? rd + 1 : 0);
      end
      if (legal) begin
        checks++;
        if (o.addr !== addr - (addr % A'(NB)) || o.we !== we || !o.stable) begin
          failures++;
          $display("FAIL rand_bus[%0d]: addr %h we %b stable %b expected %h %b 1", k, o.addr, o.we, o.stable,
                   addr - (addr % A'(NB)), we);
        end
        if (we) begin
          checks++;
          if (o.strb !== model_strb(addr, len) || o.wdata !== model_wdata(addr, wd)) begin
            failures++;
            $display("FAIL rand_store_lanes[%0d]: strb %b wdata %h expected %b %h", k, o.strb, o.wdata,
                     model_strb(addr, len), model_wdata(addr, wd));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [A-1:0] addr;
    logic [3:0] len;
    logic [D-1:0] bus, exp_rd;
    logic sign;
    for (int k = 0; k < 8; k++) begin
      len  = 4'b0001 << $urandom_range(0, 2);
      addr = (32'h8000_0040 | 32'($urandom_range(0, 63))) & ~32'(nbytes_of(len) - 1);
      sign = 1'($urandom_range(0, 1));
      bus  = rand_data();
      exp_q.push_back(model_load(addr, len, sign, bus));
      drive_txn(1'b0, addr, '0, len, sign, 0, 0, bus, o);
      exp_rd = exp_q.pop_front();
      checks++;
      if (o.rdata !== exp_rd || o.lat != 3 || o.post_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d]: rdata %h lat %0d ready %b expected %h 3 1", k, o.rdata, o.lat, o.post_ready, exp_rd);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    @(negedge clk);
    test_byte_load();
    test_half_store();
    test_backpressure();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
